// File: rtl/vx_ibuf_stage_pkg.sv
// Shared widths and the instruction-buffer entry type for vx_ibuf_stage.
// Build-time sizes fall back to defaults when the core config header has not set them.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef IBUF_SIZE
`define IBUF_SIZE 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif

package VX_gpu_types;
  typedef struct packed {
    logic [`NUM_THREADS-1:0]     tmask;
    logic [`XLEN-1:0]            PC;
    logic [31:0]                 data;
    logic [`UP(`UUID_BITS)-1:0]  uuid;
  } ibuf_entry_t;
endpackage

package vx_ibuf_stage_pkg;
  localparam int unsigned NW_WIDTH   = `UP(`NW_BITS);
  localparam int unsigned UUID_WIDTH = `UP(`UUID_BITS);

  typedef enum logic {
    SEL_FREE,
    SEL_LOCKED
  } sel_state_e;

  function automatic logic [NW_WIDTH-1:0] wrap_inc(input logic [NW_WIDTH-1:0] w,
                                                   input int unsigned n);
    return (32'(w) >= n - 1) ? '0 : w + NW_WIDTH'(1);
  endfunction
endpackage

// File: rtl/vx_ibuf_stage_fifo_queue.sv
// VX_fifo_queue: single-clock circular FIFO with occupancy count; push ignored when full,
// pop ignored when empty, head visible combinationally on data_out.
module VX_fifo_queue #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] adv(input logic [AW-1:0] p);
    return (32'(p) >= DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= adv(wr_ptr);
      if (do_pop)  rd_ptr <= adv(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/vx_ibuf_stage.sv
// vx_ibuf_stage: per-warp instruction buffers between icache response and decode, drained
// round-robin with a grant lock. Define IBUF_BYPASS_EN for 0-cycle forwarding into empty queues.
module vx_ibuf_stage
  import VX_gpu_types::*;
  import vx_ibuf_stage_pkg::*;
#(
  parameter int          CORE_ID   = 0,
  parameter int unsigned NUM_WARPS = `NUM_WARPS,
  parameter int unsigned IBUF_SIZE = `IBUF_SIZE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rsp_valid,
  output logic                    rsp_ready,
  input  logic [NW_WIDTH-1:0]     rsp_wid,
  input  logic [`NUM_THREADS-1:0] rsp_tmask,
  input  logic [`XLEN-1:0]        rsp_PC,
  input  logic [31:0]             rsp_data,
  input  logic [UUID_WIDTH-1:0]   rsp_uuid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NW_WIDTH-1:0]     out_wid,
  output logic [`NUM_THREADS-1:0] out_tmask,
  output logic [`XLEN-1:0]        out_PC,
  output logic [31:0]             out_data,
  output logic [UUID_WIDTH-1:0]   out_uuid,
  output logic [NUM_WARPS-1:0]    ibuf_pop
);
  ibuf_entry_t          rsp_entry, sel_entry;
  ibuf_entry_t          head [NUM_WARPS];
  logic [NUM_WARPS-1:0] q_empty, q_full, q_push, q_pop, cand;
  sel_state_e           state, state_n;
  logic [NW_WIDTH-1:0]  rr_ptr, lock_wid, lock_wid_n, sel_wid, hi_wid, lo_wid;
  logic                 hi_found, lo_found, sel_found;
  logic                 rsp_full, rsp_fire, out_fire, bypass;
  logic [31:0]          unused_core_id;

  assign unused_core_id = 32'(CORE_ID);
  assign rsp_entry      = {rsp_tmask, rsp_PC, rsp_data, rsp_uuid};

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_queue
    VX_fifo_queue #(
      .DATAW($bits(ibuf_entry_t)),
      .DEPTH(IBUF_SIZE)
    ) u_queue (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (q_push[w]),
      .pop      (q_pop[w]),
      .data_in  (rsp_entry),
      .data_out (head[w]),
      .empty    (q_empty[w]),
      .full     (q_full[w])
    );
  end

  // Out-of-range warp ids are never accepted.
  always_comb begin
    rsp_full = 1'b1;
    for (int unsigned w = 0; w < NUM_WARPS; w++)
      if (rsp_wid == NW_WIDTH'(w)) rsp_full = q_full[w];
  end

  assign rsp_ready = ~rsp_full;
  assign rsp_fire  = rsp_valid && rsp_ready;

`ifdef IBUF_BYPASS_EN
  logic rsp_empty, byp_req;

  always_comb begin
    rsp_empty = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++)
      if (rsp_wid == NW_WIDTH'(w)) rsp_empty = q_empty[w];
  end

  assign byp_req = rsp_fire && rsp_empty && reset_n;
  assign bypass  = byp_req && (state == SEL_FREE) && (sel_wid == rsp_wid);

  always_comb begin
    cand = ~q_empty;
    for (int unsigned w = 0; w < NUM_WARPS; w++)
      if (byp_req && rsp_wid == NW_WIDTH'(w)) cand[w] = 1'b1;
  end
`else
  assign bypass = 1'b0;
  assign cand   = ~q_empty;
`endif

  // First candidate at or above the pointer wins, else the lowest one (wrap-around search).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_wid   = '0;
    lo_wid   = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      if (cand[w] && 32'(rr_ptr) <= w && !hi_found) begin
        hi_found = 1'b1;
        hi_wid   = NW_WIDTH'(w);
      end
      if (cand[w] && !lo_found) begin
        lo_found = 1'b1;
        lo_wid   = NW_WIDTH'(w);
      end
    end
    sel_found = hi_found || lo_found;
    sel_wid   = hi_found ? hi_wid : lo_wid;
    if (state == SEL_LOCKED) begin
      sel_found = 1'b1;
      sel_wid   = lock_wid;
    end
  end

  always_comb begin
    sel_entry = head[0];
    for (int unsigned w = 0; w < NUM_WARPS; w++)
      if (sel_wid == NW_WIDTH'(w)) sel_entry = head[w];
    if (bypass) sel_entry = rsp_entry;
  end

  assign out_valid = sel_found;
  assign out_fire  = out_valid && out_ready;
  assign out_wid   = sel_wid;
  assign out_tmask = sel_entry.tmask;
  assign out_PC    = sel_entry.PC;
  assign out_data  = sel_entry.data;
  assign out_uuid  = sel_entry.uuid;

  always_comb begin
    ibuf_pop = '0;
    q_push   = '0;
    q_pop    = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      ibuf_pop[w] = out_fire && (sel_wid == NW_WIDTH'(w));
      q_pop[w]    = ibuf_pop[w] && !bypass;
      q_push[w]   = rsp_fire && (rsp_wid == NW_WIDTH'(w)) && !(bypass && out_ready);
    end
  end

  // A presented-but-stalled grant is frozen until it fires.
  always_comb begin
    state_n    = state;
    lock_wid_n = lock_wid;
    case (state)
      SEL_FREE: begin
        if (out_valid && !out_ready) begin
          state_n    = SEL_LOCKED;
          lock_wid_n = sel_wid;
        end
      end
      SEL_LOCKED: begin
        if (out_ready) state_n = SEL_FREE;
      end
      default: state_n = SEL_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEL_FREE;
      lock_wid <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_n;
      lock_wid <= lock_wid_n;
      if (out_fire) rr_ptr <= wrap_inc(sel_wid, NUM_WARPS);
    end
  end
endmodule

// File: tb/tb_vx_ibuf_stage.sv
// Self-checking bench for vx_ibuf_stage: directed scenarios plus randomized traffic
// against a queue-based reference model (honours IBUF_BYPASS_EN when defined).
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef IBUF_SIZE
`define IBUF_SIZE 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NW_BITS
`define NW_BITS 2
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif

module tb_vx_ibuf_stage;
  localparam int NW  = `NUM_WARPS;
  localparam int SZ  = `IBUF_SIZE;
  localparam int TW  = `NUM_THREADS;
  localparam int XW  = `XLEN;
  localparam int NWW = `UP(`NW_BITS);
  localparam int UW  = `UP(`UUID_BITS);
`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [TW-1:0] tmask;
    logic [XW-1:0] pc;
    logic [31:0]   data;
    logic [UW-1:0] uuid;
  } ent_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           rsp_valid = 1'b0;
  logic           rsp_ready;
  logic [NWW-1:0] rsp_wid = '0;
  logic [TW-1:0]  rsp_tmask = '0;
  logic [XW-1:0]  rsp_PC = '0;
  logic [31:0]    rsp_data = '0;
  logic [UW-1:0]  rsp_uuid = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [NWW-1:0] out_wid;
  logic [TW-1:0]  out_tmask;
  logic [XW-1:0]  out_PC;
  logic [31:0]    out_data;
  logic [UW-1:0]  out_uuid;
  logic [NW-1:0]  ibuf_pop;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  ent_t          mq [NW][$];
  int            mptr;
  bit            mlock;
  int            mlock_w;
  bit            exp_ready, exp_valid, exp_byp;
  int            exp_wid;
  ent_t          exp_ent;
  logic [NW-1:0] exp_pop;

  always #5 clk = ~clk;

  vx_ibuf_stage #(
    .CORE_ID   (0),
    .NUM_WARPS (NW),
    .IBUF_SIZE (SZ)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wid   (rsp_wid),
    .rsp_tmask (rsp_tmask),
    .rsp_PC    (rsp_PC),
    .rsp_data  (rsp_data),
    .rsp_uuid  (rsp_uuid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_wid   (out_wid),
    .out_tmask (out_tmask),
    .out_PC    (out_PC),
    .out_data  (out_data),
    .out_uuid  (out_uuid),
    .ibuf_pop  (ibuf_pop)
  );

  function automatic ent_t cur_rsp();
    return '{tmask: rsp_tmask, pc: rsp_PC, data: rsp_data, uuid: rsp_uuid};
  endfunction

  function automatic ent_t cur_out();
    return '{tmask: out_tmask, pc: out_PC, data: out_data, uuid: out_uuid};
  endfunction

  function automatic int model_total();
    int t = 0;
    for (int w = 0; w < NW; w++) t += mq[w].size();
    return t;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) mq[w].delete();
    mptr  = 0;
    mlock = 1'b0;
    mlock_w = 0;
  endtask

  // Expected outputs for the current inputs and model state.
  task automatic model_predict();
    int rw = int'(rsp_wid);
    exp_ready = (mq[rw].size() < SZ);
    exp_valid = 1'b0;
    exp_byp   = 1'b0;
    exp_wid   = 0;
    exp_ent   = '0;
    if (mlock) begin
      exp_valid = 1'b1;
      exp_wid   = mlock_w;
    end else begin
      for (int k = 0; k < NW; k++) begin
        int c = (mptr + k) % NW;
        if (!exp_valid && (mq[c].size() > 0 || (BYP && rsp_valid && exp_ready && c == rw))) begin
          exp_valid = 1'b1;
          exp_wid   = c;
        end
      end
    end
    if (exp_valid) begin
      if (mq[exp_wid].size() > 0) exp_ent = mq[exp_wid][0];
      else begin
        exp_byp = 1'b1;
        exp_ent = cur_rsp();
      end
    end
    exp_pop = '0;
    if (exp_valid && out_ready) exp_pop[exp_wid] = 1'b1;
  endtask

  task automatic model_commit();
    if (exp_valid && out_ready && !exp_byp) void'(mq[exp_wid].pop_front());
    if (rsp_valid && exp_ready && !(exp_byp && out_ready)) mq[int'(rsp_wid)].push_back(cur_rsp());
    if (exp_valid && out_ready) mptr = (exp_wid + 1) % NW;
    mlock   = exp_valid && !out_ready;
    mlock_w = exp_wid;
  endtask

  task automatic settle();
    @(negedge clk);
    model_predict();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input bit v, input int w);
    rsp_valid = v;
    rsp_wid   = NWW'(w);
    rsp_tmask = TW'($urandom);
    rsp_PC    = XW'($urandom);
    rsp_data  = $urandom;
    rsp_uuid  = UW'({$urandom, $urandom});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    rsp_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic drain();
    rsp_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < SZ * NW + 2; i++) begin
      settle();
      advance();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rsp_valid = 1'b1;
    rsp_wid   = NWW'(2);
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (ibuf_pop !== '0) begin n_err++; $display("FAIL reset_ibuf_pop: got %b expected 0", ibuf_pop); end
    n_cmp++; if (rsp_ready !== 1'b1) begin n_err++; $display("FAIL reset_rsp_ready: got %b expected 1", rsp_ready); end
    @(posedge clk);
    #1;
    rsp_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [NW-1:0] pop_w1;
    pop_w1    = '0;
    pop_w1[1] = 1'b1;
    out_ready = 1'b1;
    set_rsp(1'b1, 1);
    rsp_PC = 32'h8000_0000;
    settle();
`ifdef IBUF_BYPASS_EN
    n_cmp++; if (out_valid !== 1'b1 || out_wid !== NWW'(1) || out_PC !== 32'h8000_0000)
      begin n_err++; $display("FAIL lat_bypass_out: got v=%b wid=%0d pc=%h expected v=1 wid=1 pc=80000000", out_valid, out_wid, out_PC); end
    n_cmp++; if (ibuf_pop !== pop_w1) begin n_err++; $display("FAIL lat_bypass_pop: got %b expected %b", ibuf_pop, pop_w1); end
    advance();
    rsp_valid = 1'b0;
    settle();
`else
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_cycle0_valid: got %b expected 0", out_valid); end
    advance();
    rsp_valid = 1'b0;
    settle();
    n_cmp++; if (out_valid !== 1'b1 || out_wid !== NWW'(1) || out_PC !== 32'h8000_0000)
      begin n_err++; $display("FAIL lat_cycle1_out: got v=%b wid=%0d pc=%h expected v=1 wid=1 pc=80000000", out_valid, out_wid, out_PC); end
    n_cmp++; if (ibuf_pop !== pop_w1) begin n_err++; $display("FAIL lat_cycle1_pop: got %b expected %b", ibuf_pop, pop_w1); end
    advance();
    settle();
`endif
    n_cmp++; if (out_valid !== 1'b0 || ibuf_pop !== '0)
      begin n_err++; $display("FAIL lat_after: got v=%b pop=%b expected v=0 pop=0", out_valid, ibuf_pop); end
    advance();
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < SZ; i++) begin
      set_rsp(1'b1, 2);
      settle();
      n_cmp++; if (rsp_ready !== 1'b1) begin n_err++; $display("FAIL full_fill_ready[%0d]: got %b expected 1", i, rsp_ready); end
      advance();
    end
    rsp_valid = 1'b0;
    settle();
    n_cmp++; if (rsp_ready !== 1'b0) begin n_err++; $display("FAIL full_w2_ready: got %b expected 0", rsp_ready); end
    rsp_wid = NWW'(3);
    #1;
    n_cmp++; if (rsp_ready !== 1'b1) begin n_err++; $display("FAIL full_w3_ready: got %b expected 1", rsp_ready); end
    rsp_wid = NWW'(2);
    advance();
    set_rsp(1'b1, 2);
    out_ready = 1'b1;
    settle();
    n_cmp++; if (rsp_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_cycle_ready: got %b expected 0", rsp_ready); end
    n_cmp++; if (ibuf_pop !== exp_pop || exp_pop[2] !== 1'b1)
      begin n_err++; $display("FAIL full_pop_cycle_pop: got %b expected %b", ibuf_pop, exp_pop); end
    advance();
    out_ready = 1'b0;
    settle();
    n_cmp++; if (rsp_ready !== 1'b1) begin n_err++; $display("FAIL full_after_pop_ready: got %b expected 1", rsp_ready); end
    advance();
    rsp_valid = 1'b0;
    settle();
    n_cmp++; if (out_valid !== 1'b1 || cur_out() !== exp_ent)
      begin n_err++; $display("FAIL full_head: got v=%b %h expected v=1 %h", out_valid, cur_out(), exp_ent); end
    advance();
    drain();
  endtask

  task automatic test_round_robin();
    int wl [6]    = '{0, 0, 1, 1, 3, 3};
    int order [6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_rsp(1'b1, wl[i]);
      settle();
      advance();
    end
    rsp_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_cmp++; if (out_valid !== 1'b1 || out_wid !== NWW'(order[i]))
        begin n_err++; $display("FAIL rr_grant[%0d]: got v=%b wid=%0d expected v=1 wid=%0d", i, out_valid, out_wid, order[i]); end
      n_cmp++; if (cur_out() !== exp_ent) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", i, cur_out(), exp_ent); end
      advance();
    end
    settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_empty: got %b expected 0", out_valid); end
    advance();
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    ent_t saved;
    logic [NW-1:0] pop_w3;
    pop_w3    = '0;
    pop_w3[3] = 1'b1;
    do_reset();
    set_rsp(1'b1, 3);
    settle();
    advance();
    set_rsp(1'b1, 0);
    settle();
    saved = cur_out();
    n_cmp++; if (out_valid !== 1'b1 || out_wid !== NWW'(3) || saved !== exp_ent)
      begin n_err++; $display("FAIL hold_sel: got v=%b wid=%0d %h expected v=1 wid=3 %h", out_valid, out_wid, saved, exp_ent); end
    advance();
    rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (out_wid !== NWW'(3) || cur_out() !== saved)
        begin n_err++; $display("FAIL hold_stable[%0d]: got wid=%0d %h expected wid=3 %h", i, out_wid, cur_out(), saved); end
      advance();
    end
    out_ready = 1'b1;
    settle();
    n_cmp++; if (out_wid !== NWW'(3) || ibuf_pop !== pop_w3)
      begin n_err++; $display("FAIL hold_fire: got wid=%0d pop=%b expected wid=3 pop=%b", out_wid, ibuf_pop, pop_w3); end
    advance();
    settle();
    n_cmp++; if (out_valid !== 1'b1 || out_wid !== NWW'(0))
      begin n_err++; $display("FAIL hold_next: got v=%b wid=%0d expected v=1 wid=0", out_valid, out_wid); end
    advance();
    drain();
  endtask

  task automatic test_reset_mid();
    int wl [3] = '{1, 2, 3};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rsp(1'b1, wl[i]);
      settle();
      advance();
    end
    rsp_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || ibuf_pop !== '0 || rsp_ready !== 1'b1)
      begin n_err++; $display("FAIL rstmid_now: got v=%b pop=%b rdy=%b expected v=0 pop=0 rdy=1", out_valid, ibuf_pop, rsp_ready); end
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0 || ibuf_pop !== '0)
      begin n_err++; $display("FAIL rstmid_held: got v=%b pop=%b expected v=0 pop=0", out_valid, ibuf_pop); end
    reset_n = 1'b1;
    settle();
    n_cmp++; if (out_valid !== 1'b0 || ibuf_pop !== '0)
      begin n_err++; $display("FAIL rstmid_stale: got v=%b pop=%b expected v=0 pop=0", out_valid, ibuf_pop); end
    advance();
    out_ready = 1'b0;
    set_rsp(1'b1, 0);
    settle();
    advance();
    set_rsp(1'b1, 2);
    settle();
    advance();
    rsp_valid = 1'b0;
    out_ready = 1'b1;
    settle();
    n_cmp++; if (out_wid !== NWW'(0) || cur_out() !== exp_ent)
      begin n_err++; $display("FAIL rstmid_first: got wid=%0d %h expected wid=0 %h", out_wid, cur_out(), exp_ent); end
    advance();
    settle();
    n_cmp++; if (out_wid !== NWW'(2) || cur_out() !== exp_ent)
      begin n_err++; $display("FAIL rstmid_second: got wid=%0d %h expected wid=2 %h", out_wid, cur_out(), exp_ent); end
    advance();
    drain();
  endtask

  task automatic test_random();
    int ready_pct;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ready_pct = ((cyc / 300) % 3 == 0) ? 20 : (((cyc / 300) % 3 == 1) ? 90 : 55);
      set_rsp(($urandom % 100) < 70, int'($urandom % NW));
      out_ready = ($urandom % 100) < ready_pct;
      settle();
      n_cmp++; if (rsp_ready !== exp_ready) begin n_err++; $display("FAIL rnd_rsp_ready@%0d: got %b expected %b", cyc, rsp_ready, exp_ready); end
      n_cmp++; if (out_valid !== exp_valid) begin n_err++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", cyc, out_valid, exp_valid); end
      n_cmp++; if (ibuf_pop !== exp_pop) begin n_err++; $display("FAIL rnd_ibuf_pop@%0d: got %b expected %b", cyc, ibuf_pop, exp_pop); end
      if (exp_valid) begin
        n_cmp++; if (out_wid !== NWW'(exp_wid)) begin n_err++; $display("FAIL rnd_out_wid@%0d: got %0d expected %0d", cyc, out_wid, exp_wid); end
        n_cmp++; if (cur_out() !== exp_ent) begin n_err++; $display("FAIL rnd_payload@%0d: got %h expected %h", cyc, cur_out(), exp_ent); end
      end
      advance();
    end
    drain();
    settle();
    n_cmp++; if (out_valid !== 1'b0 || model_total() != 0)
      begin n_err++; $display("FAIL rnd_final_empty: got v=%b model=%0d expected v=0 model=0", out_valid, model_total()); end
    advance();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_full();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
    $fatal(1);
  end
endmodule

// File: doc/vx_ibuf_stage.md
VX_IBUF_STAGE -- requirements
Module: VX_ibuf_stage

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core index used only in trace messages.
REQ-002 SHALL have parameter NUM_WARPS, default `NUM_WARPS, the number of warp queues.
REQ-003 SHALL have parameter IBUF_SIZE, default `IBUF_SIZE, the entry count per warp queue.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rsp_valid, input, 1 bit: fetched instruction valid, from the icache stage.
REQ-007 SHALL have port rsp_ready, output, 1 bit: the block accepts the fetched instruction.
REQ-008 SHALL have ports rsp_wid (NW_WIDTH), rsp_tmask (`NUM_THREADS), rsp_PC (`XLEN), rsp_data (32) and rsp_uuid (UUID_WIDTH), all inputs carrying the fetch payload.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the decode-side handshake.
REQ-010 SHALL have outputs out_wid, out_tmask, out_PC, out_data and out_uuid, with the same widths as the rsp_* payload ports.
REQ-011 SHALL have port ibuf_pop, output, NUM_WARPS bits: per-warp dequeue pulse, fed back to the icache stage's pending counters.

Function
REQ-012 SHALL keep one FIFO of IBUF_SIZE entries per warp, each entry holding {tmask, PC, data, uuid}.
REQ-013 SHALL drive rsp_ready = ~full[rsp_wid]; a same-cycle pop of that warp SHALL NOT raise rsp_ready.
REQ-014 SHALL push the payload into queue rsp_wid on rsp_valid && rsp_ready.
REQ-015 SHALL select among non-empty queues round-robin, starting at the priority pointer and searching upward with wrap-around from NUM_WARPS-1 to 0.
REQ-016 SHALL, after each output fire granted to warp w, set the pointer to (w+1) mod NUM_WARPS.
REQ-017 SHALL drive out_valid and out_* combinationally from the head of the selected queue, giving 1-cycle latency from rsp fire to out_valid.
REQ-018 SHALL, while out_valid && !out_ready, hold the selected warp and the out_* values stable, even if other queues become non-empty.
REQ-019 SHALL pop the selected head on out_valid && out_ready, and in that same cycle assert ibuf_pop[out_wid] for exactly one cycle.
REQ-020 SHALL keep ibuf_pop at zero in all other bits and in all other cycles.
REQ-021 SHALL, on a simultaneous push and pop of the same non-full warp, leave its occupancy unchanged and preserve FIFO order.
REQ-022 SHALL drive out_valid=0 when every queue is empty.

Reset
REQ-023 SHALL, on reset_n low, immediately empty all queues, set the pointer to 0 and release the hold lock.
REQ-024 SHALL hold out_valid=0, ibuf_pop=0 and rsp_ready=1 while reset_n is low.
REQ-025 SHALL discard any in-flight entries when reset is asserted mid-operation, with no pops issued for them.

Configuration
REQ-026 SHALL, when IBUF_BYPASS_EN is defined, forward an arriving response to out_* in the same cycle (0-cycle latency) if its queue is empty and either no other queue is non-empty or the pointer search reaches rsp_wid first.
REQ-027 SHALL, in the bypass case, skip the write on an out fire and enqueue the response otherwise.
REQ-028 SHALL, when IBUF_BYPASS_EN is undefined, have no rsp-to-out combinational path, with latency exactly 1 cycle.

Structure
REQ-029 SHALL place the ibuf_entry_t packed struct {tmask, PC, data, uuid} in VX_gpu_types.
REQ-030 SHALL use the local widths NW_WIDTH = `UP(`NW_BITS) and UUID_WIDTH = `UP(`UUID_BITS).
REQ-031 SHALL build each per-warp queue as one VX_fifo_queue instance in a generate loop, with round-robin and lock logic local to the block.

Verification
REQ-032 SHALL check: push wid=1, PC=0x80000000 at cycle 0, out_ready=1 -> out_valid with wid=1 and PC=0x80000000 at cycle 1 (cycle 0 with IBUF_BYPASS_EN), and ibuf_pop=4'b0010 in that cycle.
REQ-033 SHALL check: IBUF_SIZE pushes to warp 2 with out_ready=0 -> rsp_ready=0 for wid=2 and rsp_ready=1 for wid=3; the next push to warp 2 is accepted only the cycle after one pop.
REQ-034 SHALL check: warps 0, 1 and 3 each hold 2 entries, out_ready=1 -> grant order 0,1,3,0,1,3.
REQ-035 SHALL check: out_ready=0 with warp 3 selected, then a push to warp 0 -> out_wid stays 3 and out_* stay stable until the fire.
REQ-036 SHALL check: reset_n pulsed low with 3 entries queued -> out_valid=0 within the same cycle, no ibuf_pop, and the next grant starts from warp 0.
